// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants, types and helper functions for the single-clock
// programmable FIFO (sync_fifo_prog) and its storage (sync_fifo_ram).
//   FIFO_MIN_DEPTH     smallest legal DEPTH
//   FIFO_DEFAULT_DEPTH depth used for the package-level level_t
//   level_width()      bits needed to hold 0..depth (pointer / level width)
//   is_pow2()          elaboration-time legality check for DEPTH
//   level_t            occupancy type for a default-depth FIFO
//   fifo_op_e          per-edge accepted operation (write / read / both)
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int FIFO_MIN_DEPTH     = 4;
    localparam int FIFO_DEFAULT_DEPTH = 16;

    // Pointers and level carry one extra bit so that DEPTH itself is
    // representable and full can be told apart from empty.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    typedef logic [level_width(FIFO_DEFAULT_DEPTH)-1:0] level_t;

    // Encoded as {read accepted, write accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port storage for sync_fifo_prog: one write port and one
// registered read port, both on clk. The array itself is never reset; only
// the read data register returns to zero on rst.
// A read of the address being written in the same cycle returns the new
// write data (write-first); the FIFO relies on this when a word is written
// straight into the head position.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds when low
//   raddr  in   read address
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            if (we && (waddr == raddr)) begin
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[raddr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// occupancy level, sticky overflow / underflow flags and synchronous clear.
// All status outputs are registered and describe the state after the edge.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through; the
// head word is then shown on data_read whenever rempty=0 and read_enable
// pops it. Without it, data_read loads the head word on the accepting read
// edge and holds otherwise.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   clear         in   synchronous flush (wins over same-cycle read/write)
//   write_enable  in   write request
//   data_write    in   write data
//   read_enable   in   read request
//   data_read     out  read data
//   af_thresh     in   almost-full threshold  (almost_full  = level >= af)
//   ae_thresh     in   almost-empty threshold (almost_empty = level <= ae)
//   wfull         out  level == DEPTH
//   rempty        out  no word available
//   almost_full   out  see af_thresh
//   almost_empty  out  see ae_thresh
//   level         out  words held, 0..DEPTH
//   overflow      out  sticky: write_enable while wfull
//   underflow     out  sticky: read_enable while rempty
// ---------------------------------------------------------------------------
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_read,
    input  logic [PTR_WIDTH:0]    af_thresh,
    input  logic [PTR_WIDTH:0]    ae_thresh,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    level,
    output logic                  overflow,
    output logic                  underflow
);

    generate
        if ((DEPTH < FIFO_MIN_DEPTH) || !is_pow2(DEPTH) ||
            (PTR_WIDTH + 1 != level_width(DEPTH))) begin : g_bad_cfg
            $error("sync_fifo_prog: DEPTH must be a power of 2 >= 4 and PTR_WIDTH = clog2(DEPTH)");
        end
    endgenerate

    typedef logic [PTR_WIDTH:0] ptr_t;

    ptr_t     wptr_reg, wptr_next;
    ptr_t     rptr_reg, rptr_next;
    ptr_t     level_reg, level_next;
    logic     wfull_reg, rempty_reg;
    logic     almost_full_reg, almost_empty_reg;
    logic     overflow_reg, underflow_reg;
    logic     wfull_next, rempty_next;
    logic     wr_accept, rd_accept;
    fifo_op_e op;

    logic                  ram_re;
    logic [PTR_WIDTH-1:0]  ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        // Flags are registered, so acceptance uses the pre-edge state: a full
        // FIFO refuses a write even when a read frees a slot on this edge.
        wr_accept = write_enable & ~wfull_reg & ~clear;
        rd_accept = read_enable & ~rempty_reg & ~clear;
        op        = fifo_op_e'({rd_accept, wr_accept});

        wptr_next = wptr_reg + ptr_t'(wr_accept);
        rptr_next = rptr_reg + ptr_t'(rd_accept);

        level_next = level_reg;
        case (op)
            OP_WRITE: level_next = level_reg + ptr_t'(1);
            OP_READ:  level_next = level_reg - ptr_t'(1);
            default:  level_next = level_reg;
        endcase

        // Same address with differing wrap bits means the writer is a whole
        // lap ahead of the reader.
        wfull_next  = (wptr_next[PTR_WIDTH-1:0] == rptr_next[PTR_WIDTH-1:0]) &&
                      (wptr_next[PTR_WIDTH] != rptr_next[PTR_WIDTH]);
        rempty_next = (wptr_next == rptr_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            level_reg        <= '0;
            wfull_reg        <= 1'b0;
            rempty_reg       <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else if (clear) begin
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            level_reg        <= '0;
            wfull_reg        <= 1'b0;
            rempty_reg       <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wptr_reg         <= wptr_next;
            rptr_reg         <= rptr_next;
            level_reg        <= level_next;
            wfull_reg        <= wfull_next;
            rempty_reg       <= rempty_next;
            // af_thresh = 0 and ae_thresh >= DEPTH fall out of these compares
            // as constant-true flags without special casing.
            almost_full_reg  <= (level_next >= af_thresh);
            almost_empty_reg <= (level_next <= ae_thresh);
            overflow_reg     <= overflow_reg | (write_enable & wfull_reg);
            underflow_reg    <= underflow_reg | (read_enable & rempty_reg);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register doubles as the output stage: it is reloaded every
    // edge from the post-edge head address, so it always holds mem[rptr].
    // A write landing on that address (write into empty, or read+write at
    // level 1) is forwarded by the RAM's write-first read. Clear freezes it.
    assign ram_re    = ~clear;
    assign ram_raddr = rptr_next[PTR_WIDTH-1:0];
`else
    // Standard mode: fetch only on an accepted read, hold otherwise.
    assign ram_re    = rd_accept;
    assign ram_raddr = rptr_reg[PTR_WIDTH-1:0];
`endif

    sync_fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wptr_reg[PTR_WIDTH-1:0]),
        .wdata (data_write),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign data_read    = ram_rdata;
    assign wfull        = wfull_reg;
    assign rempty       = rempty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
